// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network encoder front end:
// default widths and the encoder FSM state type.
package snn_pkg;

    localparam int INPUTS_DEF = 25;
    localparam int PIX_W_DEF  = 4;
    localparam int STEPS_DEF  = 20;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        FIN
    } enc_state_e;

endpackage

// File: rtl/spike_lane.sv
// One encoder lane: a PIX_W-bit phase accumulator whose overflow carry is
// registered as the lane's spike, giving a rate of pix / 2^PIX_W per step.
module spike_lane
    import snn_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [PIX_W-1:0] pix,
    output logic             spike
);

    logic [PIX_W-1:0] acc_q, acc_d;
    logic             spike_q, spike_d;
    logic [PIX_W:0]   sum;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        sum     = {1'b0, acc_q} + {1'b0, pix};
        acc_d   = acc_q;
        spike_d = 1'b0;
        if (clr) begin
            acc_d = '0;
        end else if (step) begin
            acc_d   = sum[PIX_W-1:0];
            spike_d = sum[PIX_W];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all flops sample together.
        if (rst) begin
            acc_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate encoder: latches a pixel frame on load, clears the neuron, then emits
// STEPS timesteps of per-lane spikes followed by a one-cycle done pulse.
module spike_encoder
    import snn_pkg::*;
#(
    parameter int INPUTS = INPUTS_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int STEPS  = STEPS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [INPUTS*PIX_W-1:0] pixels,
    output logic                    busy,
    output logic [INPUTS-1:0]       signals,
    output logic                    step_valid,
    output logic                    re_out,
    output logic                    done
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    enc_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [INPUTS*PIX_W-1:0] pix_q, pix_d;
    logic                    re_q, re_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic                    lane_clr, lane_step;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        re_d    = 1'b0;
        done_d  = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    pix_d   = pixels;
                    re_d    = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                valid_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pix_q   <= '0;
            re_q    <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            re_q    <= re_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Lanes step on exactly the edges where the FSM sits in RUN.
    assign lane_clr  = (state_q == CLEAR);
    assign lane_step = (state_q == RUN);

    for (genvar i = 0; i < INPUTS; i++) begin : g_lane
        spike_lane #(
            .PIX_W(PIX_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (lane_clr),
            .step (lane_step),
            .pix  (pix_q[i*PIX_W +: PIX_W]),
            .spike(signals[i])
        );
    end

    assign busy       = (state_q != IDLE);
    assign step_valid = valid_q;
    assign re_out     = re_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: a cycle-position reference model
// checked every cycle, plus literal spike-count and timing expectations.
module tb_spike_encoder;

    localparam int INPUTS = 25;
    localparam int PIX_W  = 4;
    localparam int STEPS  = 20;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    load;
    logic [INPUTS*PIX_W-1:0] pixels;
    logic                    busy;
    logic [INPUTS-1:0]       signals;
    logic                    step_valid;
    logic                    re_out;
    logic                    done;

    spike_encoder #(
        .INPUTS(INPUTS),
        .PIX_W (PIX_W),
        .STEPS (STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .pixels    (pixels),
        .busy      (busy),
        .signals   (signals),
        .step_valid(step_valid),
        .re_out    (re_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in cycles since the accepting edge.
    bit                started = 1'b0;
    bit                m_act   = 1'b0;
    int                m_pos   = 0;
    int                m_pix [INPUTS];
    logic              exp_busy, exp_re, exp_valid, exp_done;
    logic [INPUTS-1:0] exp_sig;

    task automatic model_idle();
        exp_busy  = 1'b0;
        exp_re    = 1'b0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_sig   = '0;
    endtask

    task automatic model_eval();
        int k;
        exp_busy  = (m_pos < STEPS + 2);
        exp_re    = (m_pos == 0);
        exp_valid = (m_pos >= 2) && (m_pos <= STEPS + 1);
        exp_done  = (m_pos == STEPS + 2);
        exp_sig   = '0;
        if (exp_valid) begin
            k = m_pos - 1;
            for (int i = 0; i < INPUTS; i++)
                exp_sig[i] = (((k * m_pix[i]) >> PIX_W) != (((k - 1) * m_pix[i]) >> PIX_W));
        end
    endtask

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_act = 1'b0;
            model_idle();
        end else if (m_act) begin
            m_pos++;
            model_eval();
            if (m_pos == STEPS + 2) m_act = 1'b0;
        end else if (load) begin
            m_act = 1'b1;
            m_pos = 0;
            for (int i = 0; i < INPUTS; i++) m_pix[i] = int'(pixels[i*PIX_W +: PIX_W]);
            model_eval();
        end else begin
            model_idle();
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("busy", 64'(busy), 64'(exp_busy));
            check("re_out", 64'(re_out), 64'(exp_re));
            check("step_valid", 64'(step_valid), 64'(exp_valid));
            check("done", 64'(done), 64'(exp_done));
            check("signals", 64'(signals), 64'(exp_sig));
        end
    end

    // Observation of DUT activity for the literal expectations.
    int               done_cnt = 0;
    int               step_idx = 0;
    int               lane_cnt  [INPUTS];
    logic [STEPS-1:0] lane_mask [INPUTS];

    always @(negedge clk) begin
        if (re_out === 1'b1) begin
            step_idx = 0;
            for (int i = 0; i < INPUTS; i++) begin
                lane_cnt[i]  = 0;
                lane_mask[i] = '0;
            end
        end
        if (step_valid === 1'b1) begin
            step_idx++;
            for (int i = 0; i < INPUTS; i++)
                if (signals[i] === 1'b1 && step_idx <= STEPS) begin
                    lane_cnt[i]++;
                    lane_mask[i][step_idx-1] = 1'b1;
                end
        end
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [INPUTS*PIX_W-1:0] rand_pix();
        logic [INPUTS*PIX_W-1:0] v;
        for (int i = 0; i < INPUTS; i++) v[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic start_pres(input logic [INPUTS*PIX_W-1:0] p);
        @(negedge clk);
        pixels = p;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt == start_cnt) begin
            bad++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    logic [INPUTS*PIX_W-1:0] pat;
    int                      d0;
    int                      n;

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        pixels = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_signals", 64'(signals), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All lanes at full-scale-minus-one.
        for (int i = 0; i < INPUTS; i++) pat[i*PIX_W +: PIX_W] = 4'd15;
        d0 = done_cnt;
        start_pres(pat);
        wait_done("p15", 60);
        check("p15_steps", 64'(step_idx), 64'd20);
        check("p15_lane0_cnt", 64'(lane_cnt[0]), 64'd18);
        check("p15_lane24_cnt", 64'(lane_cnt[24]), 64'd18);
        check("p15_lane0_mask", 64'(lane_mask[0]), 64'h0EFFFE);
        check("p15_dones", 64'(done_cnt - d0), 64'd1);
        repeat (3) @(negedge clk);

        // Mixed rates: lane0=8, lane1=0, rest=4.
        for (int i = 0; i < INPUTS; i++) pat[i*PIX_W +: PIX_W] = 4'd4;
        pat[0 +: PIX_W]     = 4'd8;
        pat[PIX_W +: PIX_W] = 4'd0;
        start_pres(pat);
        wait_done("mixed", 60);
        check("mixed_lane0_cnt", 64'(lane_cnt[0]), 64'd10);
        check("mixed_lane0_mask", 64'(lane_mask[0]), 64'h0AAAAA);
        check("mixed_lane1_cnt", 64'(lane_cnt[1]), 64'd0);
        check("mixed_lane2_mask", 64'(lane_mask[2]), 64'h088888);
        check("mixed_lane24_cnt", 64'(lane_cnt[24]), 64'd5);

        // Load and pixel noise during a presentation is ignored.
        d0 = done_cnt;
        start_pres(rand_pix());
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            load   = 1'($urandom_range(0, 1));
            pixels = rand_pix();
        end
        load = 1'b0;
        wait_done("noise", 40);
        repeat (4) @(negedge clk);
        check("noise_dones", 64'(done_cnt - d0), 64'd1);

        // Reset mid-RUN: no done, then a clean presentation.
        d0 = done_cnt;
        start_pres(rand_pix());
        n = 0;
        while (step_idx < 7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(step_valid), 64'd0);
        repeat (30) @(negedge clk);
        check("midrst_dones", 64'(done_cnt - d0), 64'd0);
        start_pres(rand_pix());
        wait_done("after_rst", 60);
        check("after_rst_steps", 64'(step_idx), 64'd20);

        // Load held high for 60 cycles: back-to-back presentations.
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        @(negedge clk);
        load = 1'b1;
        for (int i = 0; i < 60; i++) begin
            pixels = rand_pix();
            @(negedge clk);
        end
        check("held_dones", 64'(done_cnt - d0), 64'd2);
        load = 1'b0;
        wait_done("held_tail", 60);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            pixels = rand_pix();
            load   = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 99) == 0);
        end
        rst  = 1'b0;
        load = 1'b0;
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
